// File: rtl/blackbox_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blackbox_test_pkg
//  Description : Shared types and helpers for the black-box accumulator stage.
//  Revision    : 1.0  initial release
// ============================================================================
package blackbox_test_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    // Sample counter width; one spare bit keeps COUNT==1 at a legal 1-bit width.
    function automatic int cnt_width(input int count);
        return $clog2(count) + 1;
    endfunction

endpackage : blackbox_test_pkg
`default_nettype wire

// File: rtl/blackbox_sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : blackbox_sat_add
//  Description : Combinational accumulate operator. Wraps modulo 2^WIDTH, or
//                clamps to all-ones when BLACKBOX_ACCUM_SATURATE_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module blackbox_sat_add #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

`ifdef BLACKBOX_ACCUM_SATURATE_EN
    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum  = w_full[WIDTH] ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
`else
    assign o_sum = i_a + i_b;
`endif

endmodule : blackbox_sat_add
`default_nettype wire

// File: rtl/blackbox_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : blackbox_accumulator
//  Description : Ready/valid stage that sums COUNT accepted samples and emits
//                the total. Add mode set by BLACKBOX_ACCUM_SATURATE_EN in the
//                adder sub-module.
//  Revision    : 1.0  initial release
// ============================================================================
module blackbox_accumulator
    import blackbox_test_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int COUNT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bits
);

    localparam int               CNT_W      = cnt_width(COUNT);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(COUNT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out_bits;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_sum;
    logic             w_in_fire;
    logic             w_last;

    blackbox_sat_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .i_a   (r_acc),
        .i_b   (in_bits),
        .o_sum (w_sum)
    );

    assign w_in_fire = in_valid && in_ready;
    assign w_last    = (r_cnt == c_cnt_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ACCUM:   if (w_in_fire && w_last) w_next_state = EMIT;
            EMIT:    if (out_ready)           w_next_state = ACCUM;
            default: w_next_state = ACCUM;
        endcase
    end

    // in_ready is masked by reset so nothing is accepted while reset is held.
    always_comb begin
        in_ready  = (r_state == ACCUM) && !reset;
        out_valid = (r_state == EMIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out_bits <= '0;
        end else if (w_in_fire) begin
            if (w_last) begin
                r_out_bits <= w_sum;
                r_acc      <= '0;
                r_cnt      <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_bits = r_out_bits;

endmodule : blackbox_accumulator
`default_nettype wire

// File: tb/tb_blackbox_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blackbox_accumulator
//  Description : Self-checking bench for blackbox_accumulator (three configs).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_blackbox_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [15:0] a_in_bits = '0, a_out_bits;
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [7:0]  b_in_bits = '0, b_out_bits;
    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0;
    logic [15:0] c_in_bits = '0, c_out_bits;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          v;
        int unsigned b;
        bit          r;
        bit          rs;
    } stim_t;

    // Reference model for the WIDTH=16 COUNT=4 instance.
    int unsigned ma_q[$];
    bit          ma_emit = 1'b0;
    logic [15:0] ma_bits = '0;

    always #5 clk = ~clk;

    blackbox_accumulator #(.WIDTH(16), .COUNT(4)) u_dut_a (
        .clock(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_bits(a_in_bits), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_bits(a_out_bits)
    );

    blackbox_accumulator #(.WIDTH(8), .COUNT(2)) u_dut_b (
        .clock(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_bits(b_in_bits), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bits(b_out_bits)
    );

    blackbox_accumulator #(.WIDTH(16), .COUNT(1)) u_dut_c (
        .clock(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_bits(c_in_bits), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_bits(c_out_bits)
    );

    // Sum of a group of samples under the configured add mode.
    function automatic longint unsigned ref_sum(input int w, input int unsigned q[$]);
        longint unsigned s   = 0;
        longint unsigned max = (longint'(1) << w) - 1;
        foreach (q[i]) s += q[i];
`ifdef BLACKBOX_ACCUM_SATURATE_EN
        return (s > max) ? max : s;
`else
        return s & max;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on instance A and advance the transaction-level model.
    task automatic drive_a(input bit v, input int unsigned b, input bit r, input bit rs);
        a_in_valid  = v;
        a_in_bits   = b[15:0];
        a_out_ready = r;
        reset       = rs;
        tick();
        if (rs) begin
            ma_q.delete();
            ma_emit = 1'b0;
            ma_bits = '0;
        end else if (ma_emit) begin
            if (r) ma_emit = 1'b0;
        end else if (v) begin
            ma_q.push_back(b & 32'hFFFF);
            if (ma_q.size() == 4) begin
                ma_bits = 16'(ref_sum(16, ma_q));
                ma_q.delete();
                ma_emit = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        drive_a(0, 0, 0, 1);
        drive_a(0, 0, 0, 1);
        checks++;
        if (a_out_valid !== 1'b0 || a_out_bits !== 16'd0 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: valid=%b bits=%0d ready=%b expected 0/0/0",
                     a_out_valid, a_out_bits, a_in_ready);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0 || c_out_valid !== 1'b0 || c_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_bc: bv=%b br=%b cv=%b cr=%b expected all 0",
                     b_out_valid, b_in_ready, c_out_valid, c_in_ready);
        end
        drive_a(0, 0, 0, 0);
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: a=%b b=%b c=%b expected 1",
                     a_in_ready, b_in_ready, c_in_ready);
        end
    endtask

    task automatic test_basic();
        stim_t sq[$];
        sq = '{'{1, 1, 1, 0}, '{1, 2, 1, 0}, '{1, 3, 1, 0}, '{1, 4, 1, 0}, '{0, 0, 1, 0}, '{0, 0, 1, 0}};
        foreach (sq[i]) begin
            drive_a(sq[i].v, sq[i].b, sq[i].r, sq[i].rs);
            checks++;
            if (a_out_valid !== ma_emit || a_out_bits !== ma_bits || a_in_ready !== !ma_emit) begin
                errors++;
                $display("FAIL basic[%0d]: valid=%b bits=%0d ready=%b expected %b/%0d/%b",
                         i, a_out_valid, a_out_bits, a_in_ready, ma_emit, ma_bits, !ma_emit);
            end
            if (i == 3) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_bits !== 16'd10 || a_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_sum: valid=%b bits=%0d ready=%b expected 1/10/0",
                             a_out_valid, a_out_bits, a_in_ready);
                end
            end
            if (i == 4) begin
                checks++;
                if (a_out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_one_cycle: valid=%b expected 0", a_out_valid);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        stim_t sq[$];
        sq = '{'{1, 1, 0, 0}, '{1, 2, 0, 0}, '{1, 3, 0, 0}, '{1, 4, 0, 0}};
        for (int k = 0; k < 5; k++) sq.push_back('{1, $urandom_range(0, 65535), 0, 0});
        sq.push_back('{1, 100, 1, 0});
        sq.push_back('{1, 5, 1, 0});
        sq.push_back('{1, 6, 1, 0});
        sq.push_back('{1, 7, 1, 0});
        sq.push_back('{1, 8, 1, 0});
        foreach (sq[i]) begin
            drive_a(sq[i].v, sq[i].b, sq[i].r, sq[i].rs);
            checks++;
            if (a_out_valid !== ma_emit || a_out_bits !== ma_bits || a_in_ready !== !ma_emit) begin
                errors++;
                $display("FAIL backpressure[%0d]: valid=%b bits=%0d ready=%b expected %b/%0d/%b",
                         i, a_out_valid, a_out_bits, a_in_ready, ma_emit, ma_bits, !ma_emit);
            end
            if (i >= 4 && i <= 8) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_bits !== 16'd10 || a_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: valid=%b bits=%0d ready=%b expected 1/10/0",
                             i, a_out_valid, a_out_bits, a_in_ready);
                end
            end
        end
        checks++;
        if (a_out_valid !== 1'b1 || a_out_bits !== 16'd26) begin
            errors++;
            $display("FAIL after_stall_sum: valid=%b bits=%0d expected 1/26", a_out_valid, a_out_bits);
        end
        drive_a(0, 0, 1, 0);
    endtask

    task automatic test_reset_mid();
        stim_t sq[$];
        int unsigned seen[$];
        sq = '{'{1, 9, 1, 0}, '{1, 9, 1, 0}, '{0, 0, 1, 1}, '{1, 5, 1, 0}, '{1, 5, 1, 0},
               '{1, 5, 1, 0}, '{1, 5, 1, 0}, '{0, 0, 1, 0}, '{0, 0, 1, 0}};
        foreach (sq[i]) begin
            drive_a(sq[i].v, sq[i].b, sq[i].r, sq[i].rs);
            checks++;
            if (a_out_valid !== ma_emit || a_out_bits !== ma_bits || a_in_ready !== (!ma_emit && !sq[i].rs)) begin
                errors++;
                $display("FAIL reset_mid[%0d]: valid=%b bits=%0d ready=%b expected %b/%0d/%b",
                         i, a_out_valid, a_out_bits, a_in_ready, ma_emit, ma_bits, !ma_emit && !sq[i].rs);
            end
            if (a_out_valid === 1'b1) seen.push_back(32'(a_out_bits));
        end
        checks++;
        if (seen.size() != 1 || seen[0] != 20) begin
            errors++;
            $display("FAIL reset_mid_sums: count=%0d first=%0d expected 1 sum of 20",
                     seen.size(), (seen.size() > 0) ? seen[0] : 0);
        end
    endtask

    task automatic test_gaps();
        stim_t sq[$];
        sq = '{'{1, 1, 1, 0}, '{0, 77, 1, 0}, '{1, 2, 1, 0}, '{0, 77, 1, 0}, '{1, 3, 1, 0},
               '{0, 77, 1, 0}, '{1, 4, 1, 0}, '{0, 0, 1, 0}};
        foreach (sq[i]) begin
            drive_a(sq[i].v, sq[i].b, sq[i].r, sq[i].rs);
            checks++;
            if (a_out_valid !== ma_emit || a_out_bits !== ma_bits || a_in_ready !== !ma_emit) begin
                errors++;
                $display("FAIL gaps[%0d]: valid=%b bits=%0d ready=%b expected %b/%0d/%b",
                         i, a_out_valid, a_out_bits, a_in_ready, ma_emit, ma_bits, !ma_emit);
            end
            if (i == 6) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_bits !== 16'd10) begin
                    errors++;
                    $display("FAIL gaps_sum: valid=%b bits=%0d expected 1/10", a_out_valid, a_out_bits);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit rs;
            rs = ($urandom_range(0, 59) == 0);
            drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 65535),
                    $urandom_range(0, 2) != 0, rs);
            checks++;
            if (a_out_valid !== ma_emit || a_out_bits !== ma_bits || a_in_ready !== (!ma_emit && !rs)) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b bits=%0d ready=%b expected %b/%0d/%b",
                         i, a_out_valid, a_out_bits, a_in_ready, ma_emit, ma_bits, !ma_emit && !rs);
            end
        end
        drive_a(0, 0, 1, 1);
        drive_a(0, 0, 1, 0);
    endtask

    task automatic test_wrap8();
        int unsigned grp[$];
        logic [7:0]  exp8;
        grp  = '{200, 100};
        exp8 = 8'(ref_sum(8, grp));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_bits   = 8'd200;
        tick();
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap8_first: valid=%b ready=%b expected 0/1", b_out_valid, b_in_ready);
        end
        b_in_bits = 8'd100;
        tick();
        checks++;
        if (b_out_valid !== 1'b1 || b_out_bits !== exp8 || b_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL wrap8_sum: valid=%b bits=%0d ready=%b expected 1/%0d/0",
                     b_out_valid, b_out_bits, b_in_ready, exp8);
        end
        checks++;
`ifdef BLACKBOX_ACCUM_SATURATE_EN
        if (b_out_bits !== 8'd255) begin
`else
        if (b_out_bits !== 8'd44) begin
`endif
            errors++;
            $display("FAIL wrap8_const: bits=%0d", b_out_bits);
        end
        b_in_valid = 1'b0;
        tick();
        checks++;
        if (b_out_valid !== 1'b0 || b_out_bits !== exp8 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap8_hold: valid=%b bits=%0d ready=%b expected 0/%0d/1",
                     b_out_valid, b_out_bits, b_in_ready, exp8);
        end
    endtask

    task automatic test_count1();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        c_in_bits   = 16'd7;
        tick();
        checks++;
        if (c_out_valid !== 1'b1 || c_out_bits !== 16'd7 || c_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL count1_first: valid=%b bits=%0d ready=%b expected 1/7/0",
                     c_out_valid, c_out_bits, c_in_ready);
        end
        c_in_bits = 16'd3;
        tick();
        checks++;
        if (c_out_valid !== 1'b0 || c_out_bits !== 16'd7 || c_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL count1_gap: valid=%b bits=%0d ready=%b expected 0/7/1",
                     c_out_valid, c_out_bits, c_in_ready);
        end
        tick();
        checks++;
        if (c_out_valid !== 1'b1 || c_out_bits !== 16'd3 || c_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL count1_second: valid=%b bits=%0d ready=%b expected 1/3/0",
                     c_out_valid, c_out_bits, c_in_ready);
        end
        c_in_valid = 1'b0;
        tick();
        checks++;
        if (c_out_valid !== 1'b0 || c_out_bits !== 16'd3) begin
            errors++;
            $display("FAIL count1_end: valid=%b bits=%0d expected 0/3", c_out_valid, c_out_bits);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_gaps();
        test_random();
        test_wrap8();
        test_count1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_blackbox_accumulator
`default_nettype wire

// File: doc/blackbox_accumulator.md
# blackbox_accumulator

Parameterized, handshaked accumulator stage for the black-box test suite. It sits directly upstream of the single-cycle register and passthrough black boxes. It consumes a ready/valid stream of unsigned samples, sums a fixed number of them, and presents the total on a ready/valid output that the downstream black box registers. It exercises parameter passing (`WIDTH`, `COUNT`), clocked state, and backpressure in a black box, none of which the existing combinational black boxes cover.

## Interface
- `WIDTH`, default 16: sample and sum width in bits; must be ≥ 1.
- `COUNT`, default 4: number of accepted samples per emitted sum; must be ≥ 1.

- `clock`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  upstream sample valid.
- `in_ready`  output  1  block can accept a sample this cycle.
- `in_bits`  input  WIDTH  unsigned sample.
- `out_valid`  output  1  sum available.
- `out_ready`  input  1  downstream accepts the sum this cycle.
- `out_bits`  output  WIDTH  accumulated sum.

## Operation
- The block has two states, `ACCUM` and `EMIT`.
- Registers:
  - `acc` is WIDTH bits.
  - `cnt` is `$clog2(COUNT)+1` bits.
  - `out_bits` is registered.
- `in_ready` is 1 in `ACCUM` and 0 in `EMIT`. It is combinational from state only and is 0 while `reset` is high.
- `out_valid` is 1 exactly in `EMIT`.
- In `ACCUM`, an input fire is `in_valid && in_ready`:
  - When `cnt < COUNT-1`: `acc <= acc ⊕ in_bits` and `cnt <= cnt+1`.
  - When `cnt == COUNT-1`: `out_bits <= acc ⊕ in_bits`, `acc <= 0`, `cnt <= 0`, and the state moves to `EMIT`.
- In `EMIT`:
  - `out_bits` is held stable.
  - `in_valid` and `in_bits` are ignored, with no state change.
  - On `out_ready`, the state moves to `ACCUM` next cycle. `out_bits` keeps its last value.
- `⊕` is addition modulo 2^WIDTH by default; see Configuration.
- `COUNT == 1`: every accepted sample goes straight to `EMIT`, and `out_bits` equals the sample.
- Gaps in `in_valid` while in `ACCUM` are legal. `acc` and `cnt` hold.
- Reset mid-operation discards any partial sum and any pending output. No sum is emitted for the discarded samples.

## Timing
- Reset values: state `ACCUM`, `acc` = 0, `cnt` = 0, `out_bits` = 0, `out_valid` = 0. `in_ready` is 0 during reset and 1 in the first cycle after reset deasserts.
- Latency: `out_valid` rises in the cycle after the COUNT-th accepted sample.
- Minimum `out_valid` width: 1 cycle, when `out_ready` is held high.
- Throughput: COUNT+1 cycles per sum at best. There is one dead input cycle per sum because `in_ready` is 0 in `EMIT`.
- Ready/valid rules:
  - `out_valid`, once asserted, stays high with `out_bits` stable until an `out_ready` cycle.
  - The block never waits on `out_ready` to assert `out_valid`.
  - `in_ready` does not depend on `in_valid`.
- Reset has priority over every other event in the same cycle.

## Configuration
- Macro: `BLACKBOX_ACCUM_SATURATE_EN`.
- Defined: `⊕` is saturating addition. Any carry out of WIDTH bits clamps the result to 2^WIDTH−1. Once `acc` is saturated it stays at all-ones until the sum is emitted or reset.
- Undefined: `⊕` wraps modulo 2^WIDTH and the carry is discarded.
- The macro changes no port or parameter.

## Structure
- Shared package `blackbox_test_pkg` holds:
  - the state enum typedef (`ACCUM`, `EMIT`);
  - a localparam helper for the `cnt` width.
- One sub-module is natural: `blackbox_sat_add`.
  - Parameterized by `WIDTH`.
  - Purely combinational; performs `⊕`.
  - Contains the `BLACKBOX_ACCUM_SATURATE_EN` conditional, so the top level stays macro-free.
- The rest (FSM, counters, output register) lives in `blackbox_accumulator`.

## Test plan
- WIDTH=16, COUNT=4, `out_ready`=1, samples 1,2,3,4 back-to-back -> `out_valid` high for exactly one cycle, the cycle after the 4th; `out_bits`=10; `in_ready`=0 in that cycle.
- Same config, `out_ready`=0 for 5 cycles after the sum appears, `in_valid`=1 throughout -> `out_valid`=1 and `out_bits`=10 stable; `in_ready`=0; the next sum covers only samples accepted after `out_ready`.
- WIDTH=8, COUNT=2, samples 200 then 100 -> `out_bits`=44 without the macro; `out_bits`=255 with `BLACKBOX_ACCUM_SATURATE_EN`.
- WIDTH=16, COUNT=4: two samples of 9, pulse `reset` for 1 cycle, then samples 5,5,5,5 -> a single sum of 20; no sum ever includes the 9s.
- COUNT=1, samples 7 then 3 with `out_ready`=1 -> two sums 7 and 3, each one cycle after acceptance; in between, `in_ready` drops for one cycle.
- COUNT=4, samples 1,2,3,4 with one idle `in_valid`=0 cycle between each -> `out_bits`=10; `acc` and `cnt` hold during the idle cycles.
